sdram_mc_arbiter: RTL and testbench

- Parametrised N-channel Avalon-MM front end that arbitrates several masters (camera writer, VGA reader, disparity engine) onto the single SDRAM controller slave port.
- Round-robin grant, one single-word transaction per grant.
- Up to MAX_PEND reads in flight; a tag FIFO steers returning read data to the issuing channel.
- Sits between the pixel-pipeline masters and the SDRAM controller in the 143 MHz memory domain.

---
 rtl/sdram_arb_pkg.sv | 20 ++
 rtl/sdram_arb_tag_fifo.sv | 57 +++++
 rtl/sdram_mc_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_sdram_mc_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM controller front-end arbiter.
//   arb_state_e    : arbiter FSM states
//   ERR_*          : bit positions inside err_sticky
//   ch_id_w()      : width of a channel id for a given channel count (min 1)
package sdram_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  localparam int ERR_UNEXP_RDV = 0;  // readdatavalid with no read outstanding
  localparam int ERR_RD_WR     = 1;  // granted channel asserted read and write
  localparam int ERR_W         = 2;

  function automatic int ch_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Tag FIFO holding the channel id of every read accepted by the SDRAM
// controller and not yet returned. The head steers returning read data.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : store push_data (ignored when full and not popping)
//   pop        : discard head (ignored when empty)
//   head       : oldest stored id
//   count      : number of stored ids (0..DEPTH)
//   empty      : count == 0
module sdram_arb_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sdram_mc_arbiter.sv
// N-channel Avalon-MM arbiter in front of a single SDRAM controller slave.
// Round-robin grant, one single-word command per grant, up to MAX_PEND reads
// outstanding; a tag FIFO steers read data back to the issuing channel.
//
// Ports:
//   clk_clk, reset_reset_n        : memory clock, asynchronous active-low reset
//   ch_address/writedata/byteenable/read/write : per-channel requests, slice i = channel i
//   ch_waitrequest                : low only in the cycle a channel's command is accepted
//   ch_readdata, ch_readdatavalid : shared return data, one-hot return strobe
//   sdram_*                       : controller-side Avalon port (active-low strobes/byte enables)
//   err_sticky                    : [0] unexpected readdatavalid, [1] read+write together
//
// Optional build macro SDRAM_ARB_LOCK_EN: after an accepted command the same
// channel is re-granted ahead of round-robin for up to LOCK_LEN consecutive
// grants, keeping sequential pixel streams in the open SDRAM row.
module sdram_mc_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 8,
  parameter int LOCK_LEN = 4
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
  input  logic [NUM_CH*DATA_W-1:0]   ch_writedata,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_byteenable,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  output logic [NUM_CH-1:0]          ch_waitrequest,
  output logic [DATA_W-1:0]          ch_readdata,
  output logic [NUM_CH-1:0]          ch_readdatavalid,
  output logic [ADDR_W-1:0]          sdram_address,
  output logic [DATA_W-1:0]          sdram_writedata,
  output logic [DATA_W/8-1:0]        sdram_byteenable_n,
  output logic                       sdram_chipselect,
  output logic                       sdram_read_n,
  output logic                       sdram_write_n,
  input  logic [DATA_W-1:0]          sdram_readdata,
  input  logic                       sdram_readdatavalid,
  input  logic                       sdram_waitrequest,
  output logic [ERR_W-1:0]           err_sticky
);

  localparam int BE_W    = DATA_W / 8;
  localparam int CH_ID_W = ch_id_w(NUM_CH);
  localparam int CNT_W   = $clog2(MAX_PEND) + 1;

  if (NUM_CH < 2 || LOCK_LEN < 1 || (MAX_PEND & (MAX_PEND - 1)) != 0) begin : g_cfg_check
    $error("sdram_mc_arbiter: unsupported parameter combination");
  end

  arb_state_e          state, state_nxt;
  logic [CH_ID_W-1:0]  grant, grant_nxt, rr_ptr, rr_ptr_nxt, rr_win, pick, grant_inc;
  logic [NUM_CH-1:0]   elig;
  logic                any_elig, pend_ok;
  logic                sel_rd, sel_wr, cmd_active, accept, push, pop;
  logic [CNT_W-1:0]    pend_cnt;
  logic [CH_ID_W-1:0]  fifo_head;
  logic                fifo_empty;
  logic [ERR_W-1:0]    err_set;
  logic [NUM_CH-1:0]   rdv_p1;
  logic [DATA_W-1:0]   rdata_p1;

  // Eligibility uses the registered pending count only.
  assign pend_ok    = (pend_cnt < CNT_W'(MAX_PEND));
  assign elig       = ch_write | (ch_read & {NUM_CH{pend_ok}});
  assign any_elig   = |elig;

  assign sel_wr     = ch_write[grant];
  assign sel_rd     = ch_read[grant];
  assign cmd_active = sel_wr | sel_rd;
  assign accept     = (state == ISSUE) & cmd_active & ~sdram_waitrequest;
  assign push       = accept & sel_rd & ~sel_wr;
  assign pop        = sdram_readdatavalid & ~fifo_empty;
  assign grant_inc  = (grant == CH_ID_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;

  // Descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    rr_win = rr_ptr;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (elig[(int'(rr_ptr) + k) % NUM_CH]) rr_win = CH_ID_W'((int'(rr_ptr) + k) % NUM_CH);
    end
  end

`ifdef SDRAM_ARB_LOCK_EN
  localparam int LCK_W = $clog2(LOCK_LEN + 1);
  logic [LCK_W-1:0]   lock_cnt;
  logic [CH_ID_W-1:0] lock_ch;
  logic               lock_arm, lock_hit;

  // lock_arm is live only in the IDLE cycle right after an accept.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      lock_cnt <= '0;
      lock_ch  <= '0;
      lock_arm <= 1'b0;
    end else if (accept) begin
      lock_arm <= 1'b1;
      lock_ch  <= grant;
      if (lock_ch != grant || lock_cnt == '0) lock_cnt <= LCK_W'(1);
      else if (lock_cnt < LCK_W'(LOCK_LEN))   lock_cnt <= lock_cnt + 1'b1;
    end else if (state == IDLE) begin
      lock_arm <= 1'b0;
    end
  end

  // rr_ptr still moves past every accepted channel; the lock overrides it.
  assign lock_hit = lock_arm & elig[lock_ch] & (lock_cnt < LCK_W'(LOCK_LEN));
  assign pick     = lock_hit ? lock_ch : rr_win;
`else
  assign pick = rr_win;
`endif

  // State register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      err_sticky <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      rr_ptr     <= rr_ptr_nxt;
      err_sticky <= err_sticky | err_set;
    end
  end

  // Next-state logic; a withdrawn request returns to IDLE without moving rr_ptr.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (any_elig) begin
          state_nxt = ISSUE;
          grant_nxt = pick;
        end
      end
      ISSUE: begin
        if (!cmd_active) begin
          state_nxt = IDLE;
        end else if (!sdram_waitrequest) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = grant_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic; write wins when read and write are both set.
  always_comb begin
    sdram_chipselect = 1'b0;
    sdram_read_n     = 1'b1;
    sdram_write_n    = 1'b1;
    ch_waitrequest   = '1;
    if (state == ISSUE && cmd_active) begin
      sdram_chipselect      = 1'b1;
      sdram_write_n         = ~sel_wr;
      sdram_read_n          = sel_wr | ~sel_rd;
      ch_waitrequest[grant] = sdram_waitrequest;
    end
  end

  assign sdram_address      = ch_address[grant*ADDR_W +: ADDR_W];
  assign sdram_writedata    = ch_writedata[grant*DATA_W +: DATA_W];
  assign sdram_byteenable_n = ~ch_byteenable[grant*BE_W +: BE_W];

  always_comb begin
    err_set                = '0;
    err_set[ERR_UNEXP_RDV] = sdram_readdatavalid & fifo_empty;
    err_set[ERR_RD_WR]     = (state == ISSUE) & sel_wr & sel_rd;
  end

  sdram_arb_tag_fifo #(
    .DEPTH (MAX_PEND),
    .WIDTH (CH_ID_W)
  ) u_tag_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (push),
    .push_data (grant),
    .pop       (pop),
    .head      (fifo_head),
    .count     (pend_cnt),
    .empty     (fifo_empty)
  );

  // Stage p1: registered read return, strobe one-hot at the popped tag
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rdv_p1   <= '0;
      rdata_p1 <= '0;
    end else begin
      rdv_p1 <= pop ? ({{(NUM_CH-1){1'b0}}, 1'b1} << fifo_head) : '0;
      if (pop) rdata_p1 <= sdram_readdata;
    end
  end

  assign ch_readdatavalid = rdv_p1;
  assign ch_readdata      = rdata_p1;

endmodule

// File: tb/tb_sdram_mc_arbiter.sv
// Directed self-checking bench for sdram_mc_arbiter (NUM_CH=4, DATA_W=16,
// MAX_PEND=8). Inputs change 1 ns after the rising edge; outputs are sampled
// 2 ns after the rising edge.
module tb_sdram_mc_arbiter;

  localparam int NUM_CH   = 4;
  localparam int ADDR_W   = 25;
  localparam int DATA_W   = 16;
  localparam int BE_W     = 2;
  localparam int MAX_PEND = 8;
  localparam int LOCK_LEN = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH*ADDR_W-1:0] ch_address;
  logic [NUM_CH*DATA_W-1:0] ch_writedata;
  logic [NUM_CH*BE_W-1:0]   ch_byteenable;
  logic [NUM_CH-1:0]        ch_read, ch_write;
  logic [NUM_CH-1:0]        ch_waitrequest, ch_readdatavalid;
  logic [DATA_W-1:0]        ch_readdata;
  logic [ADDR_W-1:0]        sdram_address;
  logic [DATA_W-1:0]        sdram_writedata;
  logic [BE_W-1:0]          sdram_byteenable_n;
  logic                     sdram_chipselect, sdram_read_n, sdram_write_n;
  logic [DATA_W-1:0]        sdram_readdata;
  logic                     sdram_readdatavalid, sdram_waitrequest;
  logic [1:0]               err_sticky;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdram_mc_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND), .LOCK_LEN(LOCK_LEN)
  ) dut (
    .clk_clk             (clk),
    .reset_reset_n       (rst_n),
    .ch_address          (ch_address),
    .ch_writedata        (ch_writedata),
    .ch_byteenable       (ch_byteenable),
    .ch_read             (ch_read),
    .ch_write            (ch_write),
    .ch_waitrequest      (ch_waitrequest),
    .ch_readdata         (ch_readdata),
    .ch_readdatavalid    (ch_readdatavalid),
    .sdram_address       (sdram_address),
    .sdram_writedata     (sdram_writedata),
    .sdram_byteenable_n  (sdram_byteenable_n),
    .sdram_chipselect    (sdram_chipselect),
    .sdram_read_n        (sdram_read_n),
    .sdram_write_n       (sdram_write_n),
    .sdram_readdata      (sdram_readdata),
    .sdram_readdatavalid (sdram_readdatavalid),
    .sdram_waitrequest   (sdram_waitrequest),
    .err_sticky          (err_sticky)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [BE_W-1:0] be);
    ch_address[ch*ADDR_W +: ADDR_W]  = a;
    ch_writedata[ch*DATA_W +: DATA_W] = d;
    ch_byteenable[ch*BE_W +: BE_W]    = be;
  endtask

  task automatic clear_inputs();
    ch_read             = '0;
    ch_write            = '0;
    sdram_readdatavalid = 1'b0;
    sdram_waitrequest   = 1'b0;
    sdram_readdata      = '0;
    for (int c = 0; c < NUM_CH; c++) set_ch(c, ADDR_W'(32'h1000 + c), DATA_W'(16'hA000 + c), 2'b11);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Holds a request until the channel sees waitrequest low, then drops it.
  task automatic do_cmd(input int ch, input bit rd, input bit wr, output bit ok,
                        output logic rdn, output logic wrn, output logic [ADDR_W-1:0] addr);
    ok = 1'b0; rdn = 1'b1; wrn = 1'b1; addr = '0;
    ch_read[ch]  = rd;
    ch_write[ch] = wr;
    for (int n = 0; n < 16; n++) begin
      #1;
      if (ch_waitrequest[ch] === 1'b0) begin
        ok = 1'b1; rdn = sdram_read_n; wrn = sdram_write_n; addr = sdram_address;
      end
      tick();
      if (ok) break;
    end
    ch_read[ch]  = 1'b0;
    ch_write[ch] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    ch_write = '1;
    sdram_readdatavalid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    total++; if (ch_waitrequest !== 4'hF) begin bad++; $display("FAIL reset_waitreq: got %b want 1111", ch_waitrequest); end
    total++; if (ch_readdatavalid !== 4'h0) begin bad++; $display("FAIL reset_rdv: got %b want 0000", ch_readdatavalid); end
    total++; if (ch_readdata !== 16'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0000", ch_readdata); end
    total++; if (sdram_read_n !== 1'b1 || sdram_write_n !== 1'b1) begin bad++; $display("FAIL reset_strobes: got rd_n=%b wr_n=%b want 1 1", sdram_read_n, sdram_write_n); end
    total++; if (sdram_chipselect !== 1'b0) begin bad++; $display("FAIL reset_cs: got %b want 0", sdram_chipselect); end
    total++; if (err_sticky !== 2'b00) begin bad++; $display("FAIL reset_err: got %b want 00", err_sticky); end
    clear_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    set_ch(1, 25'h0000100, 16'hBEEF, 2'b11);
    ch_write[1] = 1'b1;
    #1;
    total++; if (sdram_write_n !== 1'b1) begin bad++; $display("FAIL sw_idle_wr_n: got %b want 1", sdram_write_n); end
    tick();
    #1;
    total++; if (sdram_write_n !== 1'b0 || sdram_chipselect !== 1'b1) begin bad++; $display("FAIL sw_issue_strobe: got wr_n=%b cs=%b want 0 1", sdram_write_n, sdram_chipselect); end
    total++; if (sdram_address !== 25'h0000100 || sdram_writedata !== 16'hBEEF) begin bad++; $display("FAIL sw_addr_data: got %h %h want 0000100 beef", sdram_address, sdram_writedata); end
    total++; if (sdram_byteenable_n !== 2'b00) begin bad++; $display("FAIL sw_be_n: got %b want 00", sdram_byteenable_n); end
    total++; if (ch_waitrequest !== 4'b1101) begin bad++; $display("FAIL sw_waitreq: got %b want 1101", ch_waitrequest); end
    tick();
    ch_write[1] = 1'b0;
    #1;
    total++; if (sdram_write_n !== 1'b1 || ch_waitrequest !== 4'hF) begin bad++; $display("FAIL sw_after: got wr_n=%b wreq=%b want 1 1111", sdram_write_n, ch_waitrequest); end
  endtask

  // All four channels write continuously; record accept order and cycle.
  task automatic test_round_robin();
    int acc_ch[$];
    int acc_cyc[$];
    int exp_ch[5];
`ifdef SDRAM_ARB_LOCK_EN
    exp_ch = '{0, 0, 0, 0, 1};
`else
    exp_ch = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    ch_write = 4'hF;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (sdram_write_n === 1'b0 && sdram_waitrequest === 1'b0) begin
        for (int j = 0; j < NUM_CH; j++) begin
          if (ch_waitrequest[j] === 1'b0) begin
            acc_ch.push_back(j);
            acc_cyc.push_back(c);
            total++; if (sdram_address !== ADDR_W'(32'h1000 + j)) begin bad++; $display("FAIL rr_addr ch%0d: got %h want %h", j, sdram_address, 32'h1000 + j); end
          end
        end
      end
      tick();
    end
    ch_write = '0;
    total++;
    if (acc_ch.size() < 5) begin
      bad++; $display("FAIL rr_count: got %0d accepts want >=5", acc_ch.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++; if (acc_ch[i] != exp_ch[i]) begin bad++; $display("FAIL rr_order[%0d]: got ch%0d want ch%0d", i, acc_ch[i], exp_ch[i]); end
        total++; if (acc_cyc[i] != 1 + 2*i) begin bad++; $display("FAIL rr_cycle[%0d]: got %0d want %0d", i, acc_cyc[i], 1 + 2*i); end
      end
    end
  endtask

  task automatic test_read_steering();
    bit ok; logic rdn, wrn; logic [ADDR_W-1:0] a;
    do_reset();
    set_ch(2, 25'h0002222, 16'h0, 2'b11);
    do_cmd(2, 1'b1, 1'b0, ok, rdn, wrn, a);
    total++; if (!ok || rdn !== 1'b0 || wrn !== 1'b1 || a !== 25'h0002222) begin bad++; $display("FAIL rs_ch2_issue: got ok=%0d rd_n=%b wr_n=%b addr=%h want 1 0 1 0002222", ok, rdn, wrn, a); end
    do_cmd(0, 1'b1, 1'b0, ok, rdn, wrn, a);
    total++; if (!ok || rdn !== 1'b0) begin bad++; $display("FAIL rs_ch0_issue: got ok=%0d rd_n=%b want 1 0", ok, rdn); end
    sdram_readdatavalid = 1'b1; sdram_readdata = 16'h1111;
    #1;
    total++; if (ch_readdatavalid !== 4'b0000) begin bad++; $display("FAIL rs_no_early: got %b want 0000", ch_readdatavalid); end
    tick();
    sdram_readdata = 16'h2222;
    #1;
    total++; if (ch_readdatavalid !== 4'b0100 || ch_readdata !== 16'h1111) begin bad++; $display("FAIL rs_ret0: got %b %h want 0100 1111", ch_readdatavalid, ch_readdata); end
    tick();
    sdram_readdatavalid = 1'b0; sdram_readdata = 16'h5A5A;
    #1;
    total++; if (ch_readdatavalid !== 4'b0001 || ch_readdata !== 16'h2222) begin bad++; $display("FAIL rs_ret1: got %b %h want 0001 2222", ch_readdatavalid, ch_readdata); end
    tick();
    #1;
    total++; if (ch_readdatavalid !== 4'b0000 || ch_readdata !== 16'h2222) begin bad++; $display("FAIL rs_hold: got %b %h want 0000 2222", ch_readdatavalid, ch_readdata); end
    total++; if (err_sticky !== 2'b00) begin bad++; $display("FAIL rs_err: got %b want 00", err_sticky); end
  endtask

  task automatic test_pending_limit();
    bit ok; logic rdn, wrn; logic [ADDR_W-1:0] a;
    int n_ok = 0;
    bit ch3_early = 1'b0;
    bit ch0_acc = 1'b0;
    bit ch3_acc = 1'b0;
    do_reset();
    for (int i = 0; i < MAX_PEND; i++) begin
      do_cmd(3, 1'b1, 1'b0, ok, rdn, wrn, a);
      if (ok) n_ok++;
    end
    total++; if (n_ok != MAX_PEND) begin bad++; $display("FAIL pl_fill: got %0d accepted want %0d", n_ok, MAX_PEND); end
    ch_read[3]  = 1'b1;
    ch_write[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (ch_waitrequest[3] === 1'b0) ch3_early = 1'b1;
      if (ch_waitrequest[0] === 1'b0) ch0_acc = 1'b1;
      tick();
      if (ch0_acc) ch_write[0] = 1'b0;
    end
    total++; if (ch3_early) begin bad++; $display("FAIL pl_stall: got ch3 accepted want stalled"); end
    total++; if (!ch0_acc) begin bad++; $display("FAIL pl_write_pass: got ch0 not accepted want accepted"); end
    sdram_readdatavalid = 1'b1; sdram_readdata = 16'h3333;
    tick();
    sdram_readdatavalid = 1'b0;
    #1;
    total++; if (ch_readdatavalid !== 4'b1000 || ch_readdata !== 16'h3333) begin bad++; $display("FAIL pl_return: got %b %h want 1000 3333", ch_readdatavalid, ch_readdata); end
    for (int c = 0; c < 8; c++) begin
      if (ch_waitrequest[3] === 1'b0) begin ch3_acc = 1'b1; break; end
      tick();
      #1;
    end
    total++; if (!ch3_acc) begin bad++; $display("FAIL pl_ninth: got ch3 not accepted want accepted"); end
    tick();
    ch_read[3] = 1'b0;
  endtask

  task automatic test_errors();
    do_reset();
    sdram_readdatavalid = 1'b1; sdram_readdata = 16'hDEAD;
    tick();
    sdram_readdatavalid = 1'b0;
    #1;
    total++; if (err_sticky !== 2'b01) begin bad++; $display("FAIL err_unexp: got %b want 01", err_sticky); end
    total++; if (ch_readdatavalid !== 4'b0000 || ch_readdata !== 16'h0) begin bad++; $display("FAIL err_no_strobe: got %b %h want 0000 0000", ch_readdatavalid, ch_readdata); end
    set_ch(1, 25'h0000777, 16'h7777, 2'b01);
    ch_read[1] = 1'b1; ch_write[1] = 1'b1;
    tick();
    #1;
    total++; if (sdram_write_n !== 1'b0 || sdram_read_n !== 1'b1) begin bad++; $display("FAIL err_rw_prio: got wr_n=%b rd_n=%b want 0 1", sdram_write_n, sdram_read_n); end
    total++; if (sdram_byteenable_n !== 2'b10 || ch_waitrequest !== 4'b1101) begin bad++; $display("FAIL err_rw_accept: got be_n=%b wreq=%b want 10 1101", sdram_byteenable_n, ch_waitrequest); end
    tick();
    ch_read[1] = 1'b0; ch_write[1] = 1'b0;
    #1;
    total++; if (err_sticky !== 2'b11) begin bad++; $display("FAIL err_rw_flag: got %b want 11", err_sticky); end
  endtask

  task automatic test_reset_mid_issue();
    bit ok; logic rdn, wrn; logic [ADDR_W-1:0] a;
    do_reset();
    do_cmd(1, 1'b1, 1'b0, ok, rdn, wrn, a);
    do_cmd(1, 1'b1, 1'b0, ok, rdn, wrn, a);
    sdram_waitrequest = 1'b1;
    ch_write[2] = 1'b1;
    tick();
    #1;
    total++; if (sdram_write_n !== 1'b0 || sdram_address !== 25'h0001002) begin bad++; $display("FAIL rm_issue: got wr_n=%b addr=%h want 0 0001002", sdram_write_n, sdram_address); end
    tick();
    #1;
    total++; if (sdram_write_n !== 1'b0 || ch_waitrequest !== 4'hF) begin bad++; $display("FAIL rm_hold: got wr_n=%b wreq=%b want 0 1111", sdram_write_n, ch_waitrequest); end
    rst_n = 1'b0;
    #1;
    total++; if (sdram_write_n !== 1'b1 || sdram_read_n !== 1'b1 || sdram_chipselect !== 1'b0) begin bad++; $display("FAIL rm_async: got wr_n=%b rd_n=%b cs=%b want 1 1 0", sdram_write_n, sdram_read_n, sdram_chipselect); end
    clear_inputs();
    tick();
    rst_n = 1'b1;
    sdram_readdatavalid = 1'b1;
    tick();
    sdram_readdatavalid = 1'b0;
    #1;
    total++; if (ch_readdatavalid !== 4'b0000 || err_sticky !== 2'b01) begin bad++; $display("FAIL rm_tags_cleared: got rdv=%b err=%b want 0000 01", ch_readdatavalid, err_sticky); end
  endtask

  // ch0 streams while ch1 waits; both hold their requests continuously.
  task automatic test_lock();
    int acc_ch[$];
    int exp_ch[6];
`ifdef SDRAM_ARB_LOCK_EN
    exp_ch = '{0, 0, 0, 0, 1, 1};
`else
    exp_ch = '{0, 1, 0, 1, 0, 1};
`endif
    do_reset();
    ch_write[0] = 1'b1;
    ch_write[1] = 1'b1;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (ch_waitrequest[0] === 1'b0) acc_ch.push_back(0);
      if (ch_waitrequest[1] === 1'b0) acc_ch.push_back(1);
      tick();
    end
    ch_write = '0;
    total++;
    if (acc_ch.size() < 6) begin
      bad++; $display("FAIL lock_count: got %0d accepts want >=6", acc_ch.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++; if (acc_ch[i] != exp_ch[i]) begin bad++; $display("FAIL lock_order[%0d]: got ch%0d want ch%0d", i, acc_ch[i], exp_ch[i]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_steering();
    test_pending_limit();
    test_errors();
    test_reset_mid_issue();
    test_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
